// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// request record and the legality/alignment check.
package lsu_pkg;
  localparam int NUM_LANES = 4;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE, ST_WRITE} lsu_state_e;

  // Only the byte offset is kept; the word address is registered at accept.
  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic req_is_bad(input logic store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic illegal, misaligned;
    illegal    = store ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    misaligned = (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
    return illegal || misaligned;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response plus word-wide memory port of the load/store unit.
interface load_store_unit_if #(parameter int ADDR_WIDTH = 13);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_error;
  logic [31:0]           resp_rdata;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_writedata;
  logic [31:0]           mem_readdata;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_readdata,
    output req_ready, resp_valid, resp_error, resp_rdata, mem_we, mem_addr, mem_writedata
  );
  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_readdata,
    input  req_ready, resp_valid, resp_error, resp_rdata, mem_we, mem_addr, mem_writedata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [NUM_LANES-1:0][7:0] w_lanes, m_lanes;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign w_lanes = word;
  assign sel_b   = w_lanes[byte_off];
  assign sel_h   = byte_off[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data = word;
    case (funct3)
      F3_LB:   load_data = {{24{sel_b[7]}}, sel_b};
      F3_LBU:  load_data = {24'd0, sel_b};
      F3_LH:   load_data = {{16{sel_h[15]}}, sel_h};
      F3_LHU:  load_data = {16'd0, sel_h};
      default: load_data = word;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    logic       hit;
    logic [7:0] src;
    always_comb begin
      hit = 1'b0;
      src = wdata[7:0];
      case (funct3[1:0])
        2'd0: hit = (byte_off == LANE);
        2'd1: begin hit = (byte_off[1] == LANE[1]); src = wdata[8*(i%2) +: 8]; end
        2'd2: begin hit = 1'b1; src = wdata[8*i +: 8]; end
        default: hit = 1'b0;
      endcase
    end
    assign m_lanes[i] = hit ? src : w_lanes[i];
  end

  assign merged = m_lanes;
endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: FSM, request register and registered response for a
// word-wide memory with 1-cycle read latency and no byte enables.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic clock,
  input  logic reset,
  load_store_unit_if.master bus
);
  lsu_state_e  state;
  lsu_req_t    req_q;
  logic [31:0] load_data, merged;
  logic        bad, q_is_sw;

  assign bus.req_ready = (state == ST_IDLE);
  assign bad           = req_is_bad(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
  assign q_is_sw       = req_q.store && req_q.funct3 == F3_SW;

  lsu_lane_align u_align (
    .funct3   (req_q.funct3),
    .byte_off (req_q.off),
    .word     (bus.mem_readdata),
    .wdata    (req_q.wdata),
    .load_data(load_data),
    .merged   (merged)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= ST_IDLE;
      req_q             <= '0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_writedata <= '0;
      bus.resp_valid    <= 1'b0;
      bus.resp_error    <= 1'b0;
      bus.resp_rdata    <= '0;
    end else begin
      bus.mem_we     <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_error <= 1'b0;
      bus.resp_rdata <= '0;
      case (state)
        ST_IDLE: if (bus.req_valid) begin
          if (bad) begin
            bus.resp_valid <= 1'b1;
            bus.resp_error <= 1'b1;
          end else begin
            req_q        <= '{store: bus.req_store, funct3: bus.req_funct3,
                              off: bus.req_addr[1:0], wdata: bus.req_wdata};
            bus.mem_addr <= bus.req_addr[ADDR_WIDTH+1:2];
            state        <= ST_ISSUE;
            // Full-word store goes straight out; sub-word stores read first.
            if (bus.req_store && bus.req_funct3 == F3_SW) begin
              bus.mem_we        <= 1'b1;
              bus.mem_writedata <= bus.req_wdata;
            end
          end
        end
        ST_ISSUE: begin
          if (q_is_sw) begin
            bus.resp_valid <= 1'b1;
            state          <= ST_IDLE;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (req_q.store) begin
            bus.mem_writedata <= merged;
            bus.mem_we        <= 1'b1;
            state             <= ST_WRITE;
          end else begin
            bus.resp_rdata <= load_data;
            bus.resp_valid <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          bus.resp_valid <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
